// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use, branch-flush and memory-wait stall control with perf counters and a sticky timeout flag
module hazard_stall_unit #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [31:0]      if_id_instr,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_m_mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic timeout_q, timeout_d;
  logic mem_stall, load_use, br, ld_stall;
  always_comb begin
    mem_stall = ex_m_mem_req & ~dmem_ready;
    load_use = id_ex_mem_read & (id_ex_rd != 5'd0) &
               ((id_ex_rd == if_id_instr[19:15]) | (id_ex_rd == if_id_instr[24:20]));
    br = ~mem_stall & ex_branch_taken;
    ld_stall = ~mem_stall & ~ex_branch_taken & load_use;
    // every control output is forced low while reset is held
    pc_write = arst_n & ~mem_stall & ~ld_stall;
    if_id_write = arst_n & ~mem_stall & ~ld_stall;
    if_id_flush = arst_n & br;
    id_ex_bubble = arst_n & (br | ld_stall);
    pipe_hold = arst_n & mem_stall;
    state_d = (state_q == RUN) ? (mem_stall ? MEM_WAIT : RUN) : (dmem_ready ? RUN : MEM_WAIT);
    wait_d = (state_q == RUN) ? (mem_stall ? 8'd0 : wait_q)
           : ((!dmem_ready && wait_q != 8'hFF) ? wait_q + 8'd1 : wait_q);
    // flag rises once MEM_TIMEOUT wait cycles have elapsed
    timeout_d = timeout_q | (state_d == MEM_WAIT && wait_d == 8'(MEM_TIMEOUT - 1));
    stall_cnt_d = ((mem_stall | ld_stall) && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (br && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= RUN;
      wait_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign mem_timeout = timeout_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed checks of hazard_stall_unit with CNT_W=3 and MEM_TIMEOUT=4
module tb_hazard_stall_unit;
  logic clk = 1'b0;
  logic arst_n;
  logic [31:0] if_id_instr;
  logic [4:0] id_ex_rd;
  logic id_ex_mem_read, ex_branch_taken, ex_m_mem_req, dmem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_timeout;
  logic [2:0] stall_cnt, flush_cnt;
  int tests = 0;
  int fails = 0;

  hazard_stall_unit #(.CNT_W(3), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .arst_n(arst_n), .if_id_instr(if_id_instr), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_m_mem_req(ex_m_mem_req), .dmem_ready(dmem_ready), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .pipe_hold(pipe_hold), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, 5'd6, 7'h33};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rst();
    arst_n = 1'b0;
    #1;
    arst_n = 1'b1;
    #1;
  endtask

  task automatic idle();
    if_id_instr = mk(5'd0, 5'd0);
    id_ex_rd = 5'd0;
    id_ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0;
    ex_m_mem_req = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic outs(input string tag, input logic [4:0] exp);
    chk(tag, {27'b0, pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}, {27'b0, exp});
  endtask

  initial begin
    arst_n = 1'b0;
    idle();
    ex_m_mem_req = 1'b1;
    #2;
    outs("reset_outs", 5'b00000);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_timeout", 32'(mem_timeout), 0);
    idle();
    cyc();
    arst_n = 1'b1;
    #1;
    outs("idle_outs", 5'b11000);

    // load-use on rs1
    id_ex_rd = 5'd5; id_ex_mem_read = 1'b1; if_id_instr = mk(5'd5, 5'd1);
    #1;
    outs("lu_stall", 5'b00010);
    cyc();
    idle();
    #1;
    outs("lu_after", 5'b11000);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);

    // no hazard: load to x0, and non-load writing x5
    rst();
    id_ex_rd = 5'd0; id_ex_mem_read = 1'b1; if_id_instr = mk(5'd0, 5'd0);
    #1;
    outs("rd0_outs", 5'b11000);
    cyc();
    id_ex_rd = 5'd5; id_ex_mem_read = 1'b0; if_id_instr = mk(5'd5, 5'd1);
    #1;
    outs("nonload_outs", 5'b11000);
    cyc();
    chk("nohaz_stall_cnt", 32'(stall_cnt), 0);
    // load-use on rs2
    id_ex_rd = 5'd1; id_ex_mem_read = 1'b1; if_id_instr = mk(5'd7, 5'd1);
    #1;
    outs("rs2_stall", 5'b00010);
    cyc();
    idle();
    chk("rs2_stall_cnt", 32'(stall_cnt), 1);

    // branch together with load-use
    rst();
    id_ex_rd = 5'd5; id_ex_mem_read = 1'b1; if_id_instr = mk(5'd5, 5'd1); ex_branch_taken = 1'b1;
    #1;
    outs("br_lu_outs", 5'b11110);
    cyc();
    idle();
    #1;
    chk("br_flush_cnt", 32'(flush_cnt), 1);
    chk("br_stall_cnt", 32'(stall_cnt), 0);

    // three wait cycles then ready
    rst();
    ex_m_mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      outs($sformatf("mw_hold%0d", i), 5'b00001);
      cyc();
    end
    dmem_ready = 1'b1;
    #1;
    outs("mw_release", 5'b11000);
    cyc();
    idle();
    #1;
    chk("mw_stall_cnt", 32'(stall_cnt), 3);
    chk("mw_state_run", 32'(dut.state_q), 0);

    // same with a branch held throughout
    rst();
    ex_m_mem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      outs($sformatf("mwb_hold%0d", i), 5'b00001);
      cyc();
    end
    dmem_ready = 1'b1;
    #1;
    outs("mwb_release", 5'b11110);
    cyc();
    idle();
    #1;
    chk("mwb_flush_cnt", 32'(flush_cnt), 1);
    chk("mwb_stall_cnt", 32'(stall_cnt), 3);

    // timeout after 4 wait cycles, sticky until reset
    rst();
    ex_m_mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("to_wait%0d", i), 32'(mem_timeout), (i >= 3) ? 1 : 0);
    end
    dmem_ready = 1'b1;
    cyc();
    idle();
    cyc();
    chk("to_sticky", 32'(mem_timeout), 1);
    chk("to_stall_sat", 32'(stall_cnt), 7);
    rst();
    chk("to_cleared", 32'(mem_timeout), 0);

    // ten load-use stalls saturate the 3-bit counter
    for (int i = 0; i < 10; i++) begin
      id_ex_rd = 5'd5; id_ex_mem_read = 1'b1; if_id_instr = mk(5'd5, 5'd1);
      cyc();
      idle();
      cyc();
    end
    chk("sat_stall_cnt", 32'(stall_cnt), 7);

    // reset in the middle of a memory wait
    ex_m_mem_req = 1'b1; dmem_ready = 1'b0;
    cyc();
    cyc();
    chk("mid_state_wait", 32'(dut.state_q), 1);
    arst_n = 1'b0;
    #1;
    outs("mid_rst_outs", 5'b00000);
    chk("mid_rst_stall_cnt", 32'(stall_cnt), 0);
    chk("mid_rst_flush_cnt", 32'(flush_cnt), 0);
    chk("mid_rst_state", 32'(dut.state_q), 0);
    arst_n = 1'b1;
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller for the 5-stage RISC-V core: the producer-side counterpart of operand forwarding. It detects hazards that forwarding cannot resolve: load-use dependencies, taken-branch wrong-path instructions and multi-cycle data-memory accesses. It drives stall, flush and bubble controls into the PC, IF/ID, ID/EX and EX/MEM registers. It also keeps saturating performance counters and a sticky memory-timeout flag.

## Interface
- CNT_W, 16, width of the performance counters stall_cnt and flush_cnt
- MEM_TIMEOUT, 255, number of consecutive MEM_WAIT cycles at which mem_timeout is set (must be ≥1 and must fit in 8 bits)

- clk  in  1  system clock; all state updates on the rising edge
- arst_n  in  1  asynchronous reset, active-low
- if_id_instr  in  32  instruction in ID; rs1 = [19:15], rs2 = [24:20]
- id_ex_rd  in  5  destination register of the instruction in EX
- id_ex_mem_read  in  1  instruction in EX is a load
- ex_branch_taken  in  1  taken branch/jump resolved in EX this cycle
- ex_m_mem_req  in  1  instruction in MEM accesses data memory
- dmem_ready  in  1  data memory completes the MEM-stage access this cycle
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_bubble  out  1  zero the control word entering ID/EX
- pipe_hold  out  1  hold ID/EX and EX/MEM; insert a bubble into MEM/WB
- stall_cnt  out  CNT_W  cycles lost to stalls (saturating)
- flush_cnt  out  CNT_W  flush events (saturating)
- mem_timeout  out  1  sticky: a memory access exceeded MEM_TIMEOUT wait cycles

## Operation
- FSM states: RUN and MEM_WAIT. An 8-bit wait_cnt tracks time spent in MEM_WAIT.
- mem_stall = ex_m_mem_req & ~dmem_ready.
  - In RUN, mem_stall causes a transition to MEM_WAIT with wait_cnt cleared.
  - In MEM_WAIT, dmem_ready=1 causes a transition back to RUN. Otherwise wait_cnt increments, saturating at 255.
- load_use = id_ex_mem_read & (id_ex_rd≠0) & (id_ex_rd==rs1 | id_ex_rd==rs2).
  - rs2 is compared for every instruction format. This is conservative: a spurious stall is acceptable, a missed one is not.
- Output priority, evaluated combinationally each cycle from state and inputs:
  1. Memory stall (mem_stall in either state):
     - pc_write=0, if_id_write=0, pipe_hold=1.
     - id_ex_bubble=0 and if_id_flush=0.
     - A pending ex_branch_taken is held and acted on once the stall releases.
  2. Else ex_branch_taken:
     - pc_write=1 (loads the target), if_id_write=1.
     - if_id_flush=1, id_ex_bubble=1.
     - load_use is ignored because the ID instruction is squashed.
  3. Else load_use:
     - pc_write=0, if_id_write=0, id_ex_bubble=1, pipe_hold=0.
     - Lasts exactly one cycle per load: next cycle the load is in MEM and forwarding covers the dependency.
  4. Else all enables =1 and all flush/bubble/hold outputs =0.
- Performance counters:
  - stall_cnt increments in every cycle with pipe_hold=1 or a load_use stall.
  - flush_cnt increments in every cycle with if_id_flush=1.
  - Both saturate at 2^CNT_W−1 and never wrap.
- Memory timeout:
  - mem_timeout is set on the cycle wait_cnt reaches MEM_TIMEOUT−1 while in MEM_WAIT with dmem_ready=0.
  - It stays set until reset. The stall itself continues; no abort is performed.

## Timing
- Reset (arst_n low, asynchronous):
  - state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
  - While reset is asserted, pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0 and pipe_hold=0.
  - After deassertion the unit operates normally from the first rising edge.
- Latency:
  - All control outputs are combinational: zero latency within the cycle.
  - The FSM, counters and mem_timeout update at the following rising edge.
- Zero-wait memory: mem_req with dmem_ready in the same cycle produces no stall and no state change.
- A memory stall of N wait cycles gives exactly N cycles of pipe_hold=1.
  - The release cycle (dmem_ready=1) has pipe_hold=0.
  - stall_cnt increases by N.
- Back-to-back accesses: a new mem_req without ready on the release cycle is impossible, because the pipeline advances on that cycle. The next MEM instruction is evaluated on the following cycle.
- Reset asserted mid-MEM_WAIT: the unit returns to RUN immediately and clears the counters.

## Test plan
- Load-use: lw x5 in EX (id_ex_rd=5, id_ex_mem_read=1) and add x6,x5,x1 in ID.
  - Expect one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; then normal flow; stall_cnt=1.
- No-hazard cases, each expecting no stall and stall_cnt=0:
  - id_ex_rd=0 with a load.
  - A non-load writing x5 with x5 as a source in ID.
- Branch plus load-use in the same cycle.
  - Expect if_id_flush=1, id_ex_bubble=1, pc_write=1, flush_cnt=1, stall_cnt=0.
- Memory wait: mem_req=1 with dmem_ready low for 3 cycles, then high.
  - Expect pipe_hold=1 for 3 cycles, 0 on the ready cycle, and state back to RUN; stall_cnt=3.
  - Repeat with ex_branch_taken=1 held throughout: expect the flush only on the ready cycle.
- Timeout: MEM_TIMEOUT=4 with dmem_ready low for 10 cycles.
  - Expect mem_timeout to rise after 4 wait cycles and stay high after release until arst_n pulses low.
- Saturation and reset: CNT_W=3 with 10 load-use stalls.
  - Expect stall_cnt=7.
  - Assert arst_n low mid-MEM_WAIT: expect all outputs 0 immediately and counters 0.
